// File: rtl/shift_pkg.sv
// Shared types for the serial frame controller: shift-register control codes
// and the frame sequencing states.
package shift_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } sr_ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } frame_state_t;

endpackage

// File: rtl/sr_core.sv
// N-bit universal shift register: hold, shift left/right with serial fill,
// or parallel load, selected by an sr_ctrl_t code.
module sr_core
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  sr_ctrl_t     i_ctrl,
  input  logic [N-1:0] i_pdata,
  input  logic         i_sin,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      case (i_ctrl)
        SHL:     r_q <= {r_q[N-2:0], i_sin};
        SHR:     r_q <= {i_sin, r_q[N-1:1]};
        LOAD:    r_q <= i_pdata;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_frame_ctrl.sv
// Full-duplex serial frame controller: loads a parallel word, shifts it out
// MSB first at DIV clocks per bit while capturing sin, then offers the result.
module shift_frame_ctrl
  import shift_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_valid,
  input  logic [N-1:0] tx_data,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [N-1:0] rx_data,
  input  logic         rx_ready,
  output logic         sout,
  input  logic         sin,
  output logic         sclk,
  output logic         busy
);

  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(N);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  if (N < 2) begin : g_bad_n
    $error("shift_frame_ctrl: N must be at least 2");
  end
  if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
    $error("shift_frame_ctrl: DIV must be even and at least 2");
  end

  frame_state_t  r_state;
  logic [DW-1:0] r_div_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          r_tx_ready;
  logic          r_rx_valid;
  logic          r_busy;
  logic          r_sclk;
  logic          r_sout_en;

  sr_ctrl_t      w_ctrl;
  logic [N-1:0]  w_q;
  logic          w_tick;
  logic [DW-1:0] w_div_nxt;

  // A bit period ends on the last divider count; that edge samples sin.
  assign w_tick    = (r_state == SHIFT) && (r_div_cnt == DIV_LAST);
  assign w_div_nxt = r_div_cnt + DW'(1);

  always_comb begin
    w_ctrl = HOLD;
    if (r_state == IDLE && tx_valid) begin
      w_ctrl = LOAD;
    end else if (w_tick) begin
      w_ctrl = SHL;
    end
  end

  sr_core #(
    .N(N)
  ) u_sr (
    .clk     (clk),
    .rst     (rst),
    .i_ctrl  (w_ctrl),
    .i_pdata (tx_data),
    .i_sin   (sin),
    .o_q     (w_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_tx_ready <= 1'b1;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_sclk     <= 1'b0;
      r_sout_en  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_valid) begin
            r_state    <= SHIFT;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_sclk     <= 1'b0;
            r_sout_en  <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            if (r_bit_cnt == BIT_LAST) begin
              r_state    <= DONE;
              r_rx_valid <= 1'b1;
              r_sout_en  <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end else begin
            r_div_cnt <= w_div_nxt;
            r_sclk    <= (w_div_nxt >= DIV_HALF);
          end
        end
        DONE: begin
          if (rx_ready) begin
            r_state    <= IDLE;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_div_cnt  <= '0;
          r_bit_cnt  <= '0;
          r_tx_ready <= 1'b1;
          r_rx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_sclk     <= 1'b0;
          r_sout_en  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = r_tx_ready;
  assign rx_valid = r_rx_valid;
  assign rx_data  = w_q;
  assign sout     = r_sout_en & w_q[N-1];
  assign sclk     = r_sclk;
  assign busy     = r_busy;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl: table of frame scenarios, hand-written reset and
// abort sequences, and random-sin frames checked against a cycle-count model.
module tb_shift_frame_ctrl;

  localparam int N   = 8;
  localparam int DIV = 4;

  localparam int M_LOOP = 0;
  localparam int M_ONE  = 1;
  localparam int M_ZERO = 2;
  localparam int M_RAND = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_valid;
  logic [N-1:0] tx_data;
  logic         tx_ready;
  logic         rx_valid;
  logic [N-1:0] rx_data;
  logic         rx_ready;
  logic         sout;
  logic         sin;
  logic         sclk;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] last_rx;

  typedef struct {
    logic [N-1:0] tx;
    int           mode;
    int           early;   // 0: none, 1: next word offered in DONE, 2: from SHIFT on
    logic [N-1:0] nxt;
    int           delay;   // cycles of rx_ready=0 in DONE
    logic [N-1:0] exp_rx;
  } vec_t;

  vec_t tbl[5];

  shift_frame_ctrl #(.N(N), .DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .sout     (sout),
    .sin      (sin),
    .sclk     (sclk),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] status();
    return {3'b000, tx_ready, rx_valid, busy, sout, sclk};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One frame from an IDLE cycle back to the next IDLE cycle.
  task automatic run_frame(input logic [N-1:0] tx, input int mode, input int early,
                           input logic [N-1:0] nxt, input int delay,
                           input logic [N-1:0] exp_tab);
    logic [N-1:0] exp_rx;
    logic [N-1:0] want;
    logic         eb;
    logic         es;
    chk("idle_status", status(), 8'b000_10100 & 8'b000_10000);
    chk("idle_rx_data", rx_data, last_rx);
    tx_valid = 1'b1;
    tx_data  = tx;
    tick();
    if (early == 2) tx_data = nxt;
    else tx_valid = 1'b0;
    exp_rx = '0;
    for (int c = 1; c <= N * DIV; c++) begin
      case (mode)
        M_LOOP:  sin = sout;
        M_ONE:   sin = 1'b1;
        M_ZERO:  sin = 1'b0;
        default: sin = 1'($urandom);
      endcase
      eb = tx[N - 1 - (c - 1) / DIV];
      es = ((c - 1) % DIV) >= (DIV / 2);
      chk("shift_status", status(), {3'b000, 1'b0, 1'b0, 1'b1, eb, es});
      if (c % DIV == 0) exp_rx = {exp_rx[N-2:0], sin};
      tick();
    end
    if (early == 1) begin
      tx_valid = 1'b1;
      tx_data  = nxt;
    end
    want = (mode == M_RAND) ? exp_rx : exp_tab;
    rx_ready = 1'b0;
    for (int d = 0; d <= delay; d++) begin
      if (d == delay) rx_ready = 1'b1;
      chk("done_status", status(), 8'b000_01100);
      chk("done_rx_data", rx_data, want);
      tick();
    end
    rx_ready = 1'b0;
    last_rx  = want;
    if (early == 0) tx_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    sin      = 1'b0;
    last_rx  = '0;

    tbl[0] = '{8'hA5, M_LOOP, 0, 8'h00, 0,  8'hA5};
    tbl[1] = '{8'h00, M_ONE,  0, 8'h00, 2,  8'hFF};
    tbl[2] = '{8'h5A, M_LOOP, 2, 8'hFF, 1,  8'h5A};
    tbl[3] = '{8'hFF, M_ZERO, 1, 8'h11, 10, 8'h00};
    tbl[4] = '{8'h11, M_LOOP, 0, 8'h00, 0,  8'h11};

    // Reset held with random inputs.
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      rx_ready = 1'($urandom);
      sin      = 1'($urandom);
      tick();
      chk("reset_status", status(), 8'b000_10000);
      chk("reset_rx_data", rx_data, 8'h00);
    end
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    rst      = 1'b1;
    tick();

    foreach (tbl[i]) begin
      run_frame(tbl[i].tx, tbl[i].mode, tbl[i].early, tbl[i].nxt, tbl[i].delay, tbl[i].exp_rx);
    end

    // Abort after three bits have been shifted.
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 3 * DIV; c++) begin
      sin = sout;
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_status", status(), 8'b000_10000);
    chk("abort_rx_data", rx_data, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle", status(), 8'b000_10000);
    end
    last_rx = '0;
    run_frame(8'h3C, M_LOOP, 0, 8'h00, 0, 8'h3C);

    // Random words with a random sin stream.
    for (int i = 0; i < 8; i++) begin
      int gap;
      run_frame(8'($urandom), M_RAND, 0, 8'h00, $urandom_range(0, 3), 8'h00);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_idle", status(), 8'b000_10000);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_frame_ctrl.md
Name: shift_frame_ctrl

Overview:
Full-duplex serial frame controller built around a universal shift register datapath. It accepts a parallel word over a valid/ready handshake and loads it into the register. It then sequences N left-shifts at a divided bit rate, driving the register MSB onto sout and capturing sin into the LSB. It returns the captured word over a second valid/ready handshake. It sits between a parallel producer/consumer and an SPI-like serial link.

Parameters:
N, 8, frame width in bits (N >= 2)
DIV, 4, clock cycles per bit period (even, DIV >= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
tx_valid  in  1  producer has a word to send
tx_data  in  N  word to send, MSB transmitted first
tx_ready  out  1  controller can accept a word (IDLE only)
rx_valid  out  1  received word available
rx_data  out  N  received word (register contents)
rx_ready  in  1  consumer accepts rx_data
sout  out  1  serial data out
sin  in  1  serial data in
sclk  out  1  serial bit clock
busy  out  1  high in SHIFT and DONE

Behaviour:
- Reset is synchronous and active-low; it is sampled only on the clk rising edge.
- While rst=0: state=IDLE, shift register=0, div_cnt=0, bit_cnt=0.
- Reset output values: tx_ready=1, rx_valid=0, rx_data=0, sout=0, sclk=0, busy=0.
- Reset asserted mid-frame aborts the frame. The next cycle shows the reset values. No partial rx_valid is produced.
- Register control codes:
  - HOLD: register keeps its value.
  - SHL: {r[N-2:0], sin}.
  - LOAD: register takes tx_data.
  - SHR is never issued.
- State IDLE:
  - tx_ready=1, register held.
  - If tx_valid=1 at an edge: LOAD tx_data, clear div_cnt and bit_cnt, go to SHIFT.
- State SHIFT:
  - sout = r[N-1].
  - div_cnt counts 0..DIV-1 and wraps.
  - sclk=0 while div_cnt < DIV/2, otherwise sclk=1.
  - At an edge with div_cnt=DIV-1: issue SHL, sampling sin at that edge, then bit_cnt++.
  - All other SHIFT edges issue HOLD.
  - At the tick where bit_cnt=N-1, go to DONE instead of incrementing.
- State DONE:
  - rx_valid=1, rx_data=register contents, register held.
  - sout=0, sclk=0.
  - If rx_ready=1 at an edge, go to IDLE.
- rx_data is the register value in every state. It is only meaningful while rx_valid=1.
- Latency: take the accepting edge at the end of cycle 0. The k-th shift (k = 1..N) happens at the end of cycle k*DIV. rx_valid is first high in cycle N*DIV+1.
- Bit timing: sout bit i (MSB first) is stable for exactly DIV cycles, from cycle (i*DIV)+1 to (i+1)*DIV.
- Counter widths:
  - div_cnt is $clog2(DIV) bits.
  - bit_cnt is $clog2(N) bits.
  - Both wrap only as specified.
- Boundary cases:
  - tx_valid outside IDLE is ignored and the word is not consumed.
  - rx_ready outside DONE is ignored.
  - In DONE with rx_ready=1 and tx_valid=1 together: go to IDLE. The new word is accepted no earlier than the following edge.
  - rx_valid and rx_data stay stable for the whole time rx_ready=0.
  - No back-to-back frames: at least one IDLE cycle between frames.

Decomposition:
- Shared package shift_pkg holds:
  - sr_ctrl_t, 2-bit codes: HOLD=2'b00, SHL=2'b01, SHR=2'b10, LOAD=2'b11.
  - frame_state_t enum: IDLE, SHIFT, DONE.
- One sub-module, sr_core: N-bit universal shift register with synchronous active-low reset, driven by sr_ctrl_t, a parallel input and a serial input.
- The FSM, div_cnt, bit_cnt and output decode live in shift_frame_ctrl.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> tx_ready=1, rx_valid=0, rx_data=0, sout=0, sclk=0, busy=0.
- Loopback (sin=sout), N=8, DIV=4, send 8'hA5 -> sout = 1,0,1,0,0,1,0,1, each bit held 4 cycles; sclk toggles 0,0,1,1 per bit; rx_valid first high 33 cycles after the accept edge; rx_data=8'hA5.
- sin tied 1, send 8'h00 -> sout=0 throughout; rx_data=8'hFF.
- Backpressure: rx_ready=0 for 10 cycles in DONE while tx_valid=1 with 8'h11 -> rx_valid and rx_data stable, tx_ready=0, no load. Then rx_ready=1 -> IDLE next cycle, and 8'h11 is accepted the edge after.
- Abort: rst=0 for one edge after 3 bits shifted -> reset values next cycle. Then loopback 8'h3C -> rx_data=8'h3C with correct timing.
- Mid-frame tx_valid: present 8'hFF during SHIFT of 8'h5A in loopback -> ignored; rx_data=8'h5A; 8'hFF is accepted only after the return to IDLE.
